// File: rtl/ifetch.sv
// ============================================================================
// Module   : ifetch
// Purpose  : Instruction-fetch stage. Issues word requests to instruction
//            memory, feeds the IF/ID register and steers the external PC
//            register through pc_en / pc_next. A one-entry skid buffer
//            absorbs a word that returns while decode is stalled. Flushes
//            that arrive with a request in flight use the DROP state, which
//            waits for and discards the stale word.
//
// Ports    : clock        - rising-edge clock
//            reset_n      - asynchronous active-low reset
//            pc           - current PC (PC register output)
//            stall        - decode cannot accept an instruction this cycle
//            flush        - branch/jump taken; PC loads its target on pc_en
//            imem_ack     - memory returns data this cycle
//            imem_rdata   - instruction word, valid with imem_ack
//            imem_req     - fetch request
//            imem_addr    - fetch word address
//            pc_en        - PC register enable
//            pc_next      - pc + 1 (sequential PC register input)
//            instr        - IF/ID instruction (NOP_INSTR when invalid)
//            instr_pc     - address of instr
//            instr_valid  - instr is valid
//            fetch_err    - sticky fetch timeout
//
// Options  : IFETCH_TIMEOUT_EN - when defined, an 8-bit no-ack counter and a
//            terminal ERR state are built; otherwise fetch_err is tied low
//            and the block waits for ack indefinitely.
//
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch #(
    parameter logic [15:0] NOP_INSTR      = 16'h0000,
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] pc,
    input  logic        stall,
    input  logic        flush,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic        pc_en,
    output logic [15:0] pc_next,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_FULL  = 3'd2,
        ST_DROP  = 3'd3
`ifdef IFETCH_TIMEOUT_EN
        ,
        ST_ERR   = 3'd4
`endif
    } state_t;

    state_t      r_state;
    logic [15:0] r_addr_q;
    logic [15:0] r_instr;
    logic [15:0] r_instr_pc;
    logic        r_instr_valid;
    logic [15:0] r_skid;
    logic [15:0] r_skid_pc;

    logic        w_imem_req;
    logic [15:0] w_imem_addr;
    logic        w_pc_en;

    // ------------------------------------------------------------------
    // State-decoded memory request and PC enable. In FETCH the address is
    // the live pc so a fresh PC is requested in the same cycle it appears.
    // ------------------------------------------------------------------
    always_comb begin
        w_imem_req  = 1'b0;
        w_imem_addr = r_addr_q;
        w_pc_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pc_en = flush;
            end
            ST_FETCH: begin
                w_imem_req  = 1'b1;
                w_imem_addr = pc;
                // Any returned word (kept or discarded) or a flush advances the PC.
                w_pc_en     = flush | imem_ack;
            end
            ST_FULL: begin
                w_pc_en = flush;
            end
            ST_DROP: begin
                w_imem_req = 1'b1;
                w_pc_en    = flush;
            end
            default: begin
                w_imem_req  = 1'b0;
                w_imem_addr = r_addr_q;
                w_pc_en     = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential control and datapath.
    // ------------------------------------------------------------------
`ifdef IFETCH_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic       r_fetch_err;
    logic [7:0] w_tmo_inc;

    assign w_tmo_inc = r_tmo_cnt + 8'd1;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_addr_q      <= 16'h0000;
            r_instr       <= NOP_INSTR;
            r_instr_pc    <= 16'h0000;
            r_instr_valid <= 1'b0;
            r_skid        <= 16'h0000;
            r_skid_pc     <= 16'h0000;
`ifdef IFETCH_TIMEOUT_EN
            r_tmo_cnt     <= 8'd0;
            r_fetch_err   <= 1'b0;
`endif
        end else begin
            // A consumed or flushed instruction leaves the IF/ID register
            // empty unless a new word is loaded below in the same cycle.
            if (flush || !stall) begin
                r_instr_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    r_addr_q <= pc;
                    if (flush) begin
                        // Word returning with the flush is dropped here; without
                        // an ack the in-flight request must be drained first.
                        if (!imem_ack) begin
                            r_state <= ST_DROP;
                        end
                    end else if (imem_ack) begin
                        if (!r_instr_valid || !stall) begin
                            r_instr       <= imem_rdata;
                            r_instr_pc    <= pc;
                            r_instr_valid <= 1'b1;
                        end else begin
                            r_skid    <= imem_rdata;
                            r_skid_pc <= pc;
                            r_state   <= ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (flush) begin
                        r_state <= ST_FETCH;
                    end else if (!stall) begin
                        r_instr       <= r_skid;
                        r_instr_pc    <= r_skid_pc;
                        r_instr_valid <= 1'b1;
                        r_state       <= ST_FETCH;
                    end
                end
                ST_DROP: begin
                    // Stale word is discarded; PC already holds the target.
                    if (imem_ack) begin
                        r_state <= ST_FETCH;
                    end
                end
`ifdef IFETCH_TIMEOUT_EN
                ST_ERR: begin
                    r_instr_valid <= 1'b0;
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

`ifdef IFETCH_TIMEOUT_EN
            // Overrides any transition chosen above once the limit is hit.
            if (r_state == ST_FETCH || r_state == ST_DROP) begin
                if (imem_ack) begin
                    r_tmo_cnt <= 8'd0;
                end else begin
                    r_tmo_cnt <= w_tmo_inc;
                    if (w_tmo_inc == TIMEOUT_CYCLES) begin
                        r_fetch_err   <= 1'b1;
                        r_state       <= ST_ERR;
                        r_instr_valid <= 1'b0;
                    end
                end
            end
`endif
        end
    end

    assign imem_req    = w_imem_req;
    assign imem_addr   = w_imem_addr;
    assign pc_en       = w_pc_en;
    assign pc_next     = pc + 16'd1;
    assign instr       = r_instr_valid ? r_instr : NOP_INSTR;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;

`ifdef IFETCH_TIMEOUT_EN
    assign fetch_err = r_fetch_err;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
    assign fetch_err    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifetch.sv
// ============================================================================
// Module   : tb_ifetch
// Purpose  : Directed self-checking bench for ifetch. Models the external PC
//            register (loads pc_next, or the flush target, when pc_en=1) and
//            a simple instruction memory whose word is a fixed function of
//            the address.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch;

    localparam logic [15:0] c_nop = 16'hE000;

    logic        clock;
    logic        reset_n;
    logic [15:0] pc;
    logic        stall;
    logic        flush;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        pc_en;
    logic [15:0] pc_next;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        fetch_err;

    logic [15:0] target;
    int          n_checks;
    int          n_fail;

    ifetch #(
        .NOP_INSTR      (c_nop),
        .TIMEOUT_CYCLES (8'd255)
    ) u_dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pc          (pc),
        .stall       (stall),
        .flush       (flush),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .pc_en       (pc_en),
        .pc_next     (pc_next),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .fetch_err   (fetch_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] memw(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    // One clock: sample PC-register inputs before the edge, update the PC
    // model just after it, and present the memory word for the new pc.
    task automatic tick();
        logic        en;
        logic [15:0] nx;
        #1;
        en = pc_en;
        nx = flush ? target : pc_next;
        @(posedge clock);
        #1;
        if (!reset_n)  pc = 16'h0000;
        else if (en)   pc = nx;
        imem_rdata = memw(pc);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; pc = 16'h1234; stall = 1'b0; flush = 1'b0;
        imem_ack = 1'b1; imem_rdata = 16'h1111; target = 16'h0000;
        tick(); tick();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
        n_checks++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr got=%h exp=0000", imem_addr); end
        n_checks++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL reset_pc_en got=%0b exp=0", pc_en); end
        n_checks++; if (instr !== c_nop) begin n_fail++; $display("FAIL reset_instr got=%h exp=%h", instr, c_nop); end
        n_checks++; if (instr_pc !== 16'h0000) begin n_fail++; $display("FAIL reset_instr_pc got=%h exp=0000", instr_pc); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", instr_valid); end
        n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0b exp=0", fetch_err); end
    endtask

    task automatic test_stream();
        reset_n = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stream_cycle1_req got=%0b exp=0", imem_req); end
        tick();
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL stream_cycle2_req got=%0b exp=1", imem_req); end
        n_checks++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL stream_first_addr got=%h exp=0000", imem_addr); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL stream_pc_en[%0d] got=%0b exp=1", i, pc_en); end
            tick();
            n_checks++;
            if (instr_pc !== 16'(i) || instr !== memw(16'(i)) || instr_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_word[%0d] got pc=%h instr=%h v=%0b exp pc=%h instr=%h v=1",
                         i, instr_pc, instr, instr_valid, 16'(i), memw(16'(i)));
            end
        end
    endtask

    task automatic test_stall_skid();
        // pc=4, instr holds word 3.
        stall = 1'b1; imem_rdata = 16'hABCD;
        #1;
        n_checks++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL skid_pc_en got=%0b exp=1", pc_en); end
        tick();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL skid_full_req got=%0b exp=0", imem_req); end
        n_checks++; if (instr !== memw(16'h0003) || instr_pc !== 16'h0003) begin n_fail++; $display("FAIL skid_instr_held got=%h@%h exp=%h@0003", instr, instr_pc, memw(16'h0003)); end
        tick();
        n_checks++; if (pc_en !== 1'b0 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL skid_hold got pc_en=%0b v=%0b req=%0b exp 0/1/0", pc_en, instr_valid, imem_req); end
        stall = 1'b0;
        tick();
        n_checks++; if (instr !== 16'hABCD || instr_pc !== 16'h0004 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL skid_release got=%h@%h v=%0b exp=abcd@0004 v=1", instr, instr_pc, instr_valid); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0005) begin n_fail++; $display("FAIL skid_resume got req=%0b addr=%h exp 1/0005", imem_req, imem_addr); end
    endtask

    task automatic test_flush_drop();
        // FETCH, pc=5, instr valid; flush with no ack.
        imem_ack = 1'b0; flush = 1'b1; target = 16'h0100;
        #1;
        n_checks++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL drop_flush_pc_en got=%0b exp=1", pc_en); end
        tick();
        flush = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0005) begin n_fail++; $display("FAIL drop_addr got req=%0b addr=%h exp 1/0005", imem_req, imem_addr); end
        n_checks++; if (instr_valid !== 1'b0 || instr !== c_nop) begin n_fail++; $display("FAIL drop_cleared got v=%0b instr=%h exp 0/%h", instr_valid, instr, c_nop); end
        n_checks++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL drop_pc_en got=%0b exp=0", pc_en); end
        tick(); tick();
        n_checks++; if (imem_addr !== 16'h0005 || imem_req !== 1'b1) begin n_fail++; $display("FAIL drop_stable got req=%0b addr=%h exp 1/0005", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        #1;
        n_checks++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL drop_ack_pc_en got=%0b exp=0", pc_en); end
        tick();
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL drop_late_discard got v=%0b exp=0", instr_valid); end
        n_checks++; if (imem_addr !== 16'h0100 || imem_req !== 1'b1) begin n_fail++; $display("FAIL drop_target_addr got req=%0b addr=%h exp 1/0100", imem_req, imem_addr); end
        tick();
        n_checks++; if (instr !== memw(16'h0100) || instr_pc !== 16'h0100) begin n_fail++; $display("FAIL drop_target_word got=%h@%h exp=%h@0100", instr, instr_pc, memw(16'h0100)); end
    endtask

    task automatic test_flush_ack();
        // FETCH, pc=0x101; flush coincides with ack.
        flush = 1'b1; imem_rdata = 16'h7777; target = 16'h0200;
        tick();
        flush = 1'b0;
        #1;
        n_checks++; if (instr_valid !== 1'b0 || imem_addr !== 16'h0200 || imem_req !== 1'b1) begin n_fail++; $display("FAIL flack got v=%0b addr=%h req=%0b exp 0/0200/1", instr_valid, imem_addr, imem_req); end
        tick();
        n_checks++; if (instr !== memw(16'h0200) || instr_pc !== 16'h0200) begin n_fail++; $display("FAIL flack_next got=%h@%h exp=%h@0200", instr, instr_pc, memw(16'h0200)); end
    endtask

    task automatic test_drain();
        imem_ack = 1'b0; stall = 1'b1;
        tick();
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0200) begin n_fail++; $display("FAIL drain_stall_hold got v=%0b pc=%h exp 1/0200", instr_valid, instr_pc); end
        stall = 1'b0;
        tick();
        n_checks++; if (instr_valid !== 1'b0 || instr !== c_nop) begin n_fail++; $display("FAIL drain_clear got v=%0b instr=%h exp 0/%h", instr_valid, instr, c_nop); end
    endtask

    task automatic test_full_flush();
        imem_ack = 1'b1;
        tick();
        n_checks++; if (instr_pc !== 16'h0201) begin n_fail++; $display("FAIL ffl_load got pc=%h exp=0201", instr_pc); end
        stall = 1'b1;
        tick();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL ffl_full got req=%0b exp=0", imem_req); end
        flush = 1'b1; target = 16'h0300;
        #1;
        n_checks++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL ffl_pc_en got=%0b exp=1", pc_en); end
        tick();
        flush = 1'b0; stall = 1'b0;
        #1;
        n_checks++; if (instr_valid !== 1'b0 || imem_addr !== 16'h0300) begin n_fail++; $display("FAIL ffl_after got v=%0b addr=%h exp 0/0300", instr_valid, imem_addr); end
        tick();
        n_checks++; if (instr !== memw(16'h0300) || instr_pc !== 16'h0300) begin n_fail++; $display("FAIL ffl_skid_discard got=%h@%h exp=%h@0300", instr, instr_pc, memw(16'h0300)); end
    endtask

    task automatic test_wrap();
        flush = 1'b1; target = 16'hFFFF;
        tick();
        flush = 1'b0;
        #1;
        n_checks++; if (pc_next !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc_next got=%h exp=0000", pc_next); end
        tick();
        n_checks++; if (instr_pc !== 16'hFFFF || imem_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_fetch got ipc=%h addr=%h exp ffff/0000", instr_pc, imem_addr); end
    endtask

    task automatic test_reset_mid();
        imem_ack = 1'b0;
        tick();
        #1; reset_n = 1'b0; #1;
        n_checks++; if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_async got req=%0b addr=%h v=%0b exp 0/0000/0", imem_req, imem_addr, instr_valid); end
        tick();
        reset_n = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_cycle1 got req=%0b exp=0", imem_req); end
        tick();
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_cycle2 got req=%0b exp=1", imem_req); end
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        while (fetch_err !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
`ifdef IFETCH_TIMEOUT_EN
        n_checks++; if (n != 255 || fetch_err !== 1'b1) begin n_fail++; $display("FAIL tmo_cycles got n=%0d err=%0b exp 255/1", n, fetch_err); end
        n_checks++; if (imem_req !== 1'b0 || pc_en !== 1'b0) begin n_fail++; $display("FAIL tmo_err_outputs got req=%0b pc_en=%0b exp 0/0", imem_req, pc_en); end
        flush = 1'b1; imem_ack = 1'b1;
        #1;
        n_checks++; if (pc_en !== 1'b0) begin n_fail++; $display("FAIL tmo_err_flush got pc_en=%0b exp=0", pc_en); end
        tick();
        flush = 1'b0;
        n_checks++; if (fetch_err !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_sticky got err=%0b v=%0b exp 1/0", fetch_err, instr_valid); end
`else
        n_checks++; if (n != 300 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL tmo_none got n=%0d err=%0b exp 300/0", n, fetch_err); end
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL tmo_none_req got=%0b exp=1", imem_req); end
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_stream();
        test_stall_skid();
        test_flush_drop();
        test_flush_ack();
        test_drain();
        test_full_flush();
        test_wrap();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
